// File: rtl/pkt_meter_pkg.sv
// Shared types and helpers for pkt_flow_rate_meter.
// Packet counters are built only with PKT_FLOW_RATE_METER_PKTS_EN.
`ifndef PKT_METER_FLOW_STAT_T
`define PKT_METER_FLOW_STAT_T(W) struct packed { \
  logic [(W)-1:0] l1; \
  logic [(W)-1:0] l2; \
  logic [(W)-1:0] pkts; \
}
`endif

package pkt_meter_pkg;

  // 12 idle + 8 preamble bytes charged on every eop
  localparam int unsigned IFG_BYTES = 20;
  localparam int unsigned STAT_W    = 32;

  typedef `PKT_METER_FLOW_STAT_T(STAT_W) flow_stat_t;

  function automatic logic [15:0] beat_bytes(
    input logic        val,
    input logic        eop,
    input logic [7:0]  empty,
    input int unsigned d_width
  );
    logic [15:0] full;
    full = 16'(d_width / 8);
    if (!val) return 16'd0;
    return eop ? full - 16'(empty) : full;
  endfunction

endpackage

// File: rtl/pkt_win_timer.sv
// Window tick counter for pkt_flow_rate_meter.
// Counts 0..WINDOW_TICKS-1 while enabled; flags the last tick.
module pkt_win_timer
  import pkt_meter_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = 156250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic end_tick_o
);

  localparam int unsigned TW = $clog2(WINDOW_TICKS);
  localparam logic [TW-1:0] LAST = TW'(WINDOW_TICKS - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign end_tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pkt_flow_rate_meter.sv
// Per-flow L1/L2 byte and packet meter with windowed snapshot bank.
// Optional packet counters: define PKT_FLOW_RATE_METER_PKTS_EN.
module pkt_flow_rate_meter
  import pkt_meter_pkg::*;
#(
  parameter int unsigned D_WIDTH      = 64,
  parameter int unsigned EMPTY_WIDTH  = 3,
  parameter int unsigned FLOW_CNT     = 16,
  parameter int unsigned FLOW_W       = $clog2(FLOW_CNT),
  parameter int unsigned WINDOW_TICKS = 156250,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   val,
  input  logic                   sop,
  input  logic                   eop,
  input  logic [EMPTY_WIDTH-1:0] empty,
  input  logic [FLOW_W-1:0]      flow_num,
  output logic                   win_done,
  output logic                   bad_flow,
  input  logic                   rd_req,
  input  logic [FLOW_W-1:0]      rd_flow,
  output logic                   rd_val,
  output logic [CNT_W-1:0]       rd_l1_bytes,
  output logic [CNT_W-1:0]       rd_l2_bytes,
  output logic [CNT_W-1:0]       rd_pkts
);

  localparam int unsigned SW = ((CNT_W > 16) ? CNT_W : 16) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef `PKT_METER_FLOW_STAT_T(CNT_W) stat_t;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [15:0]      b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'(CMAX)) ? CMAX : s[CNT_W-1:0];
  endfunction

  logic        end_tick;
  logic        in_range;
  logic        cnt_beat;
  logic        hit;
  logic [15:0] l2_b, l1_b;
  logic        unused_sop;

  stat_t run_q [FLOW_CNT];
  stat_t run_d [FLOW_CNT];
  stat_t res_q [FLOW_CNT];
  stat_t res_d [FLOW_CNT];
  stat_t sum   [FLOW_CNT];
  stat_t rd_q, rd_d;

  logic win_done_q, bad_flow_q, rd_val_q;

  assign unused_sop = sop;

  pkt_win_timer #(
    .WINDOW_TICKS(WINDOW_TICKS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .end_tick_o(end_tick)
  );

  assign in_range = {1'b0, flow_num} < (FLOW_W+1)'(FLOW_CNT);
  assign cnt_beat = val && en && in_range;
  assign l2_b = beat_bytes(cnt_beat, eop, 8'(empty), D_WIDTH);
  assign l1_b = l2_b + ((cnt_beat && eop) ? 16'(IFG_BYTES) : 16'd0);

  // the end-tick beat lands in the closing window via sum
  always_comb begin
    hit = 1'b0;
    for (int f = 0; f < FLOW_CNT; f++) begin
      hit = cnt_beat && (flow_num == FLOW_W'(f));
      sum[f] = '0;
      sum[f].l1 = sat_add(run_q[f].l1, hit ? l1_b : 16'd0);
      sum[f].l2 = sat_add(run_q[f].l2, hit ? l2_b : 16'd0);
`ifdef PKT_FLOW_RATE_METER_PKTS_EN
      sum[f].pkts = sat_add(run_q[f].pkts, 16'(hit && eop));
`else
      sum[f].pkts = '0;
`endif
      run_d[f] = end_tick ? '0 : sum[f];
      res_d[f] = end_tick ? sum[f] : res_q[f];
    end
  end

  // reads see res_q, so a same-cycle snapshot is not visible yet
  always_comb begin
    rd_d = rd_q;
    if (rd_req) begin
      rd_d = '0;
      for (int f = 0; f < FLOW_CNT; f++) begin
        if (rd_flow == FLOW_W'(f)) rd_d = res_q[f];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < FLOW_CNT; f++) begin
        run_q[f] <= '0;
        res_q[f] <= '0;
      end
      rd_q       <= '0;
      win_done_q <= 1'b0;
      bad_flow_q <= 1'b0;
      rd_val_q   <= 1'b0;
    end else begin
      for (int f = 0; f < FLOW_CNT; f++) begin
        run_q[f] <= run_d[f];
        res_q[f] <= res_d[f];
      end
      rd_q       <= rd_d;
      win_done_q <= end_tick;
      bad_flow_q <= val && !in_range;
      rd_val_q   <= rd_req;
    end
  end

  assign win_done    = win_done_q;
  assign bad_flow    = bad_flow_q;
  assign rd_val      = rd_val_q;
  assign rd_l1_bytes = rd_q.l1;
  assign rd_l2_bytes = rd_q.l2;
  assign rd_pkts     = rd_q.pkts;

endmodule

// File: tb/tb_pkt_flow_rate_meter.sv
// Scoreboard bench for pkt_flow_rate_meter (W=100, 6 flows, 8-bit counters).
module tb_pkt_flow_rate_meter;

  localparam int FC   = 6;
  localparam int W    = 100;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 0;
  logic       rst_n, en, val, sop, eop, rd_req;
  logic [2:0] empty, flow_num, rd_flow;
  logic       win_done, bad_flow, rd_val;
  logic [7:0] rd_l1_bytes, rd_l2_bytes, rd_pkts;

  pkt_flow_rate_meter #(
    .D_WIDTH(64), .EMPTY_WIDTH(3), .FLOW_CNT(FC),
    .FLOW_W(3), .WINDOW_TICKS(W), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .val(val), .sop(sop), .eop(eop),
    .empty(empty), .flow_num(flow_num),
    .win_done(win_done), .bad_flow(bad_flow),
    .rd_req(rd_req), .rd_flow(rd_flow),
    .rd_val(rd_val), .rd_l1_bytes(rd_l1_bytes),
    .rd_l2_bytes(rd_l2_bytes), .rd_pkts(rd_pkts)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_edges = 0;
  always @(posedge clk) n_edges <= n_edges + 1;

  typedef struct { int l1; int l2; int pk; } rexp_t;
  rexp_t rd_exp[$];
  int    win_exp[$];
  int    bad_exp[$];

  int run_l1[FC], run_l2[FC], run_pk[FC];
  int res_l1[FC], res_l2[FC], res_pk[FC];
  int tick = 0;
  bit wrapped = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < FC; f++) begin
      run_l1[f] = 0; run_l2[f] = 0; run_pk[f] = 0;
      res_l1[f] = 0; res_l2[f] = 0; res_pk[f] = 0;
    end
    tick = 0;
  endtask

  // drive one cycle and advance the reference model for it
  task automatic step(input bit e, input bit v, input bit s, input bit eo,
                      input int emp, input int fl, input bit rq, input int rf);
    int tag, l1, l2;
    rexp_t x;
    en = e; val = v; sop = s; eop = eo;
    empty = 3'(emp); flow_num = 3'(fl);
    rd_req = rq; rd_flow = 3'(rf);
    tag = n_edges + 1;
    if (rq) begin
      x = '{0, 0, 0};
      if (rf < FC) begin
        x.l1 = res_l1[rf]; x.l2 = res_l2[rf];
`ifdef PKT_FLOW_RATE_METER_PKTS_EN
        x.pk = res_pk[rf];
`endif
      end
      rd_exp.push_back(x);
    end
    if (v && fl >= FC) bad_exp.push_back(tag);
    if (e) begin
      if (v && fl < FC) begin
        l2 = eo ? 8 - emp : 8;
        l1 = l2 + (eo ? 20 : 0);
        run_l1[fl] = sat(run_l1[fl] + l1);
        run_l2[fl] = sat(run_l2[fl] + l2);
        if (eo) run_pk[fl] = sat(run_pk[fl] + 1);
      end
      if (tick == W - 1) begin
        for (int f = 0; f < FC; f++) begin
          res_l1[f] = run_l1[f]; res_l2[f] = run_l2[f]; res_pk[f] = run_pk[f];
          run_l1[f] = 0; run_l2[f] = 0; run_pk[f] = 0;
        end
        win_exp.push_back(tag);
        wrapped = 1;
        tick = 0;
      end else begin
        tick++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int f);
    step(1, 0, 0, 0, 0, 0, 1, f);
  endtask

  task automatic idle_to_end();
    int guard = 0;
    wrapped = 0;
    while (!wrapped && guard < 3 * W) begin
      idle();
      guard++;
    end
  endtask

  task automatic chk_queues_empty();
    @(negedge clk); #1;
    check("pending_rd", rd_exp.size(), 0);
    check("pending_win_done", win_exp.size(), 0);
    check("pending_bad_flow", bad_exp.size(), 0);
  endtask

  task automatic chk_reset_outs();
    check("rst_win_done", win_done, 0);
    check("rst_bad_flow", bad_flow, 0);
    check("rst_rd_val", rd_val, 0);
    check("rst_rd_l1", rd_l1_bytes, 0);
    check("rst_rd_l2", rd_l2_bytes, 0);
    check("rst_rd_pkts", rd_pkts, 0);
  endtask

  // monitor: pops an expectation whenever the DUT presents an output
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_done) begin
        if (win_exp.size() == 0) check("win_done_unexpected", 1, 0);
        else check("win_done_edge", n_edges, win_exp.pop_front());
      end
      if (bad_flow) begin
        if (bad_exp.size() == 0) check("bad_flow_unexpected", 1, 0);
        else check("bad_flow_edge", n_edges, bad_exp.pop_front());
      end
      if (rd_val) begin
        if (rd_exp.size() == 0) check("rd_val_unexpected", 1, 0);
        else begin
          rexp_t x;
          x = rd_exp.pop_front();
          check("rd_l1", rd_l1_bytes, x.l1);
          check("rd_l2", rd_l2_bytes, x.l2);
          check("rd_pkts", rd_pkts, x.pk);
        end
      end
    end
  end

  initial begin
    rst_n = 0; en = 0; val = 0; sop = 0; eop = 0;
    empty = 0; flow_num = 0; rd_req = 0; rd_flow = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1;

    // 64-byte packet on flow 3, 61-byte on flow 0, one bad flow beat
    for (int i = 0; i < 8; i++) step(1, 1, i == 0, i == 7, 0, 3, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, i == 0, i == 7, (i == 7) ? 3 : 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 6, 0, 0);
    idle_to_end();
    for (int f = 0; f < 8; f++) rd(f);

    // single-beat packet exactly on the end tick
    while (tick != W - 1) idle();
    step(1, 1, 1, 1, 0, 2, 0, 0);
    rd(2);
    idle_to_end();
    rd(2);

    // saturation: 40 full beats on flow 1
    idle_to_end();
    for (int i = 0; i < 40; i++) step(1, 1, i == 0, 0, 0, 1, 0, 0);
    idle_to_end();
    rd(1);

    // enable pause mid-window, then reads around the snapshot
    idle_to_end();
    for (int i = 0; i < 30; i++) step(1, i % 2 == 0, 0, i % 4 == 0, 2, 4, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 1, 0, 1, 0, 4, 0, 0);
    while (tick != W - 1) idle();
    step(1, 0, 0, 0, 0, 0, 1, 4);
    rd(4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, v, eo, rq;
      int emp, fl, rf;
      e  = ($urandom_range(0, 9) != 0);
      v  = $urandom_range(0, 1);
      eo = ($urandom_range(0, 3) == 0);
      emp = eo ? $urandom_range(0, 7) : 0;
      fl = $urandom_range(0, 7);
      rq = ($urandom_range(0, 4) == 0);
      rf = $urandom_range(0, 7);
      step(e, v, 0, eo, emp, fl, rq, rf);
    end
    for (int i = 0; i < 3; i++) idle();
    chk_queues_empty();

    // reset mid-window discards partial counts and results
    for (int i = 0; i < 30; i++) step(1, 1, 0, i % 3 == 0, 1, i % FC, 0, 0);
    for (int i = 0; i < 3; i++) idle();
    chk_queues_empty();
    en = 0; val = 0; rd_req = 0;
    rst_n = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1;
    for (int f = 0; f < FC; f++) rd(f);
    idle_to_end();
    rd(0);
    for (int i = 0; i < 3; i++) idle();
    chk_queues_empty();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
